// File: rtl/alu_muldiv_seq_if.sv
// Request/response and ALU-operand signals of the MULTU/DIVU sequencer.
// master = the sequencer itself; slave = its surroundings (CPU issuing start, ALU answering).
interface alu_muldiv_seq_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic             is_div;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic [WIDTH-1:0] alu_opA;
  logic [WIDTH-1:0] alu_opB;
  logic [3:0]       alu_ALUop;
  logic [WIDTH-1:0] alu_result;
  logic             alu_zero;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    input  start, is_div, srcA, srcB, alu_result, alu_zero,
    output alu_opA, alu_opB, alu_ALUop, busy, done, hi, lo
  );

  modport slave (
    output start, is_div, srcA, srcB, alu_result, alu_zero,
    input  alu_opA, alu_opB, alu_ALUop, busy, done, hi, lo
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Iterative MULTU/DIVU sequencer: one shared-ALU add/sub per cycle for WIDTH steps, owns HI/LO.
// Handshake: start is taken only while busy=0; busy stays high until the done cycle, and done pulses once when HI/LO are final.
module alu_muldiv_seq #(
  parameter int         WIDTH  = 32,
  parameter logic [3:0] OP_ADD = 4'b0010,
  parameter logic [3:0] OP_SUB = 4'b0110
) (
  input  logic                clk,
  input  logic                reset,
  alu_muldiv_seq_if.master    bus,
  output logic [1:0]          dbg_state
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] hi_q, lo_q, opb_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] rem;
  logic             msb;
  logic             last;
  logic [WIDTH-1:0] sum;
  logic             carry;

  assign rem  = {hi_q[WIDTH-2:0], lo_q[WIDTH-1]};
  assign msb  = hi_q[WIDTH-1];
  assign last = (cnt_q == CNT_W'(WIDTH-1));
  // carry out of hi+mcand recovered from the WIDTH-bit ALU result
  assign sum   = lo_q[0] ? bus.alu_result : hi_q;
  assign carry = lo_q[0] & (bus.alu_result < hi_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.start) begin
        if (!bus.is_div)           state_d = S_MUL;
        else if (bus.srcB == '0)   state_d = S_DONE;
        else                       state_d = S_DIV;
      end
      S_MUL, S_DIV: if (last) state_d = S_DONE;
      S_DONE:       state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus.busy      = (state_q != S_IDLE);
    bus.done      = (state_q == S_DONE);
    bus.alu_opA   = '0;
    bus.alu_opB   = '0;
    bus.alu_ALUop = OP_ADD;
    case (state_q)
      S_MUL: begin
        bus.alu_opA = hi_q;
        bus.alu_opB = opb_q;
      end
      S_DIV: begin
        bus.alu_opA   = rem;
        bus.alu_opB   = opb_q;
        bus.alu_ALUop = OP_SUB;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi_q  <= '0;
      lo_q  <= '0;
      opb_q <= '0;
      cnt_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start) begin
          cnt_q <= '0;
          if (!bus.is_div) begin
            hi_q  <= '0;
            lo_q  <= bus.srcB;
            opb_q <= bus.srcA;
          end else if (bus.srcB == '0) begin
            hi_q <= bus.srcA;
            lo_q <= '1;
          end else begin
            hi_q  <= '0;
            lo_q  <= bus.srcA;
            opb_q <= bus.srcB;
          end
        end
        S_MUL: begin
          {hi_q, lo_q} <= {carry, sum, lo_q[WIDTH-1:1]};
          if (!last) cnt_q <= cnt_q + 1'b1;
        end
        S_DIV: begin
          // msb set means the shifted remainder exceeds WIDTH bits, so it always covers the divisor
          if (msb || (rem >= opb_q)) begin
            hi_q <= bus.alu_result;
            lo_q <= {lo_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_q <= rem;
            lo_q <= {lo_q[WIDTH-2:0], 1'b0};
          end
          if (!last) cnt_q <= cnt_q + 1'b1;
        end
        S_DONE: cnt_q <= '0;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (bus.alu_zero == (bus.alu_result == '0));
  end

  assign bus.hi    = hi_q;
  assign bus.lo    = lo_q;
  assign dbg_state = state_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Bench for alu_muldiv_seq: combinational ALU model, directed cases plus random MULTU/DIVU against a 64-bit arithmetic reference.
module tb_alu_muldiv_seq;
  localparam int         W      = 32;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_state;
  int         tests = 0;
  int         fails = 0;
  logic [2*W-1:0] exp_q[$];

  alu_muldiv_seq_if #(.WIDTH(W)) bus ();

  alu_muldiv_seq #(.WIDTH(W), .OP_ADD(OP_ADD), .OP_SUB(OP_SUB)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.master),
    .dbg_state (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  // shared ALU, combinational
  assign bus.alu_result = (bus.alu_ALUop == OP_SUB) ? bus.alu_opA - bus.alu_opB
                                                     : bus.alu_opA + bus.alu_opB;
  assign bus.alu_zero   = (bus.alu_result == '0);

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [2*W-1:0] ref_model(input logic d, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] prod;
    if (!d) begin
      prod = {{W{1'b0}}, a} * {{W{1'b0}}, b};
      return prod;
    end
    if (b == '0) return {a, {W{1'b1}}};
    return {a % b, a / b};
  endfunction

  // driver: issue one op, optionally re-pulse start mid-operation, then score HI/LO and timing
  task automatic run_op(input string tag, input logic d, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit repulse);
    int             cycles;
    int             exp_lat;
    logic [2*W-1:0] exp;
    exp_q.push_back(ref_model(d, a, b));
    exp_lat = (d && b == '0) ? 1 : W + 1;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_div = d;
    bus.srcA   = a;
    bus.srcB   = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.srcA  = $urandom;
    bus.srcB  = $urandom;
    cycles = 1;
    check({tag, "_busy"}, 64'(bus.busy), 64'd1);
    if (exp_lat != 1)
      check({tag, "_aluop"}, 64'(bus.alu_ALUop), d ? 64'(OP_SUB) : 64'(OP_ADD));
    while (!bus.done && cycles < 100) begin
      bus.start  = (repulse && cycles == 3);
      bus.is_div = repulse ? ~d : d;
      @(negedge clk);
      cycles++;
    end
    bus.start = 1'b0;
    exp = exp_q.pop_front();
    check({tag, "_latency"}, 64'(cycles), 64'(exp_lat));
    check({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
    @(negedge clk);
    check({tag, "_done_pulse"}, {62'd0, bus.done, bus.busy}, 64'd0);
    check({tag, "_hold"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    logic       saw_done;
    logic       d;
    logic [W-1:0] a, b;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.is_div = 1'b0;
    bus.srcA   = '0;
    bus.srcB   = '0;
    repeat (2) @(negedge clk);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("rst_flags", {62'd0, bus.busy, bus.done}, 64'd0);
    check("rst_alu", {bus.alu_opA, bus.alu_opB}, 64'd0);
    check("rst_aluop", 64'(bus.alu_ALUop), 64'(OP_ADD));
    reset = 1'b0;

    run_op("t1_mul_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("t2_mul_7x6", 1'b0, 32'd7, 32'd6, 1'b1);
    run_op("t3_div_100_7", 1'b1, 32'd100, 32'd7, 1'b0);
    run_op("t3_div_8000", 1'b1, 32'h8000_0000, 32'd3, 1'b0);
    run_op("t4_div_msb", 1'b1, 32'hFFFF_FFFF, 32'h8000_0001, 1'b0);
    run_op("t5_div_zero", 1'b1, 32'd5, 32'd0, 1'b0);
    check("t1_const_hilo", 64'(ref_model(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF)), 64'hFFFF_FFFE_0000_0001);

    // reset mid-MULTU
    @(negedge clk);
    bus.start  = 1'b1;
    bus.is_div = 1'b0;
    bus.srcA   = 32'h1234_5678;
    bus.srcB   = 32'h9ABC_DEF1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t6_abort_busy", {62'd0, bus.busy, bus.done}, 64'd0);
    check("t6_abort_hilo", {bus.hi, bus.lo}, 64'd0);
    check("t6_abort_state", 64'(dbg_state), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      saw_done |= bus.done;
    end
    check("t6_no_done", 64'(saw_done), 64'd0);
    run_op("t6_after", 1'b0, 32'h1234_5678, 32'h9ABC_DEF1, 1'b0);

    for (int i = 0; i < 20; i++) begin
      d = 1'($urandom_range(0, 1));
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom;
        default: b = {1'b1, 31'($urandom)};
      endcase
      run_op(d ? "rnd_div" : "rnd_mul", d, a, b, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
